// File: rtl/ppcm_prog_nexys3.sv
// Purpose: write engine for the parallel PCM; programs a 32-bit word as two CFI half-word programs.
// Latency: ack in cycle 14P+1 after accept when the first poll is ready; each extra poll adds 2P.
// Backpressure: busy_o high while engaged; cs_i is ignored until busy_o drops at completion.
module ppcm_prog_nexys3 #(
  parameter int CLK_FREQ   = 100,
  parameter int ADDR_BITS  = 24,
  parameter int TIMEOUT_US = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cs_i,
  input  logic [ADDR_BITS-3:0] addr_i,
  input  logic [31:0]          din_i,
  output logic                 busy_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 pcm_ce_n_o,
  output logic                 pcm_rst_n_o,
  output logic                 pcm_oe_n_o,
  output logic                 pcm_we_n_o,
  output logic [ADDR_BITS-2:0] pcm_addr_o,
  input  logic [15:0]          pcm_din_i,
  output logic [15:0]          pcm_dout_o,
  output logic                 pcm_dout_t_o
);

  // Cycles per bus phase, rounded up so each strobe level lasts at least 70 ns.
  localparam int P        = (CLK_FREQ * 70 + 999) / 1000;
  localparam int TO_LIMIT = TIMEOUT_US * CLK_FREQ;
  localparam int CW       = $clog2(2 * P);
  localparam int TW       = $clog2(TO_LIMIT + 1);

  localparam logic [CW-1:0] PH_LAST    = CW'(2 * P - 1);
  localparam logic [CW-1:0] PH_SAMPLE  = CW'(P - 1);
  localparam logic [CW-1:0] PH_HI_FROM = CW'(P);
  localparam logic [TW-1:0] TO_MAX     = TW'(TO_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DATA, S_POLL, S_CLR, S_ARRAY, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   half_q, half_d;
  logic [ADDR_BITS-3:0]   addr_q, addr_d;
  logic [31:0]            din_q, din_d;
  logic                   err_q, err_d;
  logic                   rdy_q, rdy_d;
  logic                   fail_q, fail_d;
  logic [TW-1:0]          to_q, to_d;

  logic phase_end;
  logic strobe_low;

  // Status bits other than ready and the three error flags carry no meaning here.
  logic unused_sr;
  assign unused_sr = ^{pcm_din_i[15:8], pcm_din_i[6:5], pcm_din_i[2], pcm_din_i[0]};

  assign phase_end  = (cnt_q == PH_LAST);
  assign strobe_low = (cnt_q < PH_HI_FROM);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

  // Next-state: phase counter, command sequencing, status decode and poll timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    addr_d  = addr_q;
    din_d   = din_q;
    err_d   = err_q;
    rdy_d   = rdy_q;
    fail_d  = fail_q;
    to_d    = to_q;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = phase_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cs_i) begin
          addr_d  = addr_i;
          din_d   = din_i;
          half_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (phase_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (phase_end) begin
          state_d = S_POLL;
          to_d    = '0;
        end
      end
      S_POLL: begin
        // Timeout spans all polls of one half-word and saturates at its limit.
        if (to_q != TO_MAX) to_d = to_q + TW'(1);
        // Status is captured on the last cycle of the oe_n low window.
        if (cnt_q == PH_SAMPLE) begin
          rdy_d  = pcm_din_i[7];
          fail_d = pcm_din_i[4] | pcm_din_i[3] | pcm_din_i[1];
        end
        // Decisions wait for the end of the phase so oe_n is already high.
        if (phase_end) begin
          if (rdy_q) begin
            if (fail_q) begin
              err_d   = 1'b1;
              state_d = S_CLR;
            end else if (!half_q) begin
              half_d  = 1'b1;
              state_d = S_CMD;
            end else begin
              state_d = S_ARRAY;
            end
          end else if (to_q >= TO_MAX) begin
            err_d   = 1'b1;
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        if (phase_end) state_d = S_ARRAY;
      end
      S_ARRAY: begin
        if (phase_end) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin drive per state; reset overrides everything in the same cycle.
  always_comb begin
    busy_o       = 1'b0;
    ack_o        = 1'b0;
    pcm_ce_n_o   = 1'b1;
    pcm_oe_n_o   = 1'b1;
    pcm_we_n_o   = 1'b1;
    pcm_dout_o   = 16'h0000;
    pcm_dout_t_o = 1'b1;
    pcm_addr_o   = {addr_q, half_q};
    err_o        = err_q;
    pcm_rst_n_o  = ~rst_i;

    case (state_q)
      S_CMD, S_DATA, S_CLR, S_ARRAY: begin
        busy_o       = 1'b1;
        pcm_ce_n_o   = 1'b0;
        pcm_dout_t_o = 1'b0;
        pcm_we_n_o   = ~strobe_low;
        case (state_q)
          S_CMD:   pcm_dout_o = 16'h0040;
          S_DATA:  pcm_dout_o = half_q ? din_q[31:16] : din_q[15:0];
          S_CLR:   pcm_dout_o = 16'h0050;
          default: pcm_dout_o = 16'h00FF;
        endcase
        // Read-array mode is restored at the even half of the word.
        if (state_q == S_ARRAY) pcm_addr_o = {addr_q, 1'b0};
      end
      S_POLL: begin
        busy_o     = 1'b1;
        pcm_ce_n_o = 1'b0;
        pcm_oe_n_o = ~strobe_low;
      end
      S_DONE: begin
        ack_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase

    if (rst_i) begin
      busy_o       = 1'b0;
      ack_o        = 1'b0;
      err_o        = 1'b0;
      pcm_ce_n_o   = 1'b1;
      pcm_oe_n_o   = 1'b1;
      pcm_we_n_o   = 1'b1;
      pcm_dout_o   = 16'h0000;
      pcm_dout_t_o = 1'b1;
      pcm_addr_o   = '0;
    end
  end

endmodule

// File: tb/tb_ppcm_prog_nexys3.sv
// Bench for ppcm_prog_nexys3: table of program operations with a polled-status device model,
// plus hand sequences for reset, cs held through busy, and mid-operation reset.
// Timeout is shortened to 1 us so the stuck-status case stays short.
module tb_ppcm_prog_nexys3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cs_i = 1'b0;
  logic [21:0] addr_i = '0;
  logic [31:0] din_i = '0;
  logic        busy_o, ack_o, err_o;
  logic        pcm_ce_n_o, pcm_rst_n_o, pcm_oe_n_o, pcm_we_n_o;
  logic [22:0] pcm_addr_o;
  logic [15:0] pcm_din_i = 16'h0000;
  logic [15:0] pcm_dout_o;
  logic        pcm_dout_t_o;

  always #5 clk_i = ~clk_i;

  ppcm_prog_nexys3 #(.CLK_FREQ(100), .ADDR_BITS(24), .TIMEOUT_US(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .addr_i(addr_i), .din_i(din_i),
    .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o),
    .pcm_ce_n_o(pcm_ce_n_o), .pcm_rst_n_o(pcm_rst_n_o), .pcm_oe_n_o(pcm_oe_n_o),
    .pcm_we_n_o(pcm_we_n_o), .pcm_addr_o(pcm_addr_o), .pcm_din_i(pcm_din_i),
    .pcm_dout_o(pcm_dout_o), .pcm_dout_t_o(pcm_dout_t_o)
  );

  typedef struct {
    logic [21:0]      addr;
    logic [31:0]      din;
    int               nb0;
    logic [7:0]       sr0;
    int               nb1;
    logic [7:0]       sr1;
    int               ack;
    logic             err;
    int               nwr;
    logic [5:0][22:0] wa;
    logic [5:0][15:0] wd;
  } vec_t;

  vec_t vt[6];

  int total = 0;
  int bad = 0;

  int          cyc;
  bit          mon_en;
  logic        p_we, p_oe, p_dt, p_ack;
  int          we_lo, oe_lo;
  logic [22:0] wa_log[16];
  logic [15:0] wd_log[16];
  int          nwr, cmd_cnt, poll_k;
  int          nb[2];
  logic [7:0]  srv[2];
  int          ack_cyc, ack_n, ack_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [21:0] a, input logic [31:0] d,
                         input int n0, input logic [7:0] s0, input int n1, input logic [7:0] s1,
                         input int ack, input logic err, input int nw);
    vt[i].addr = a; vt[i].din = d;
    vt[i].nb0 = n0; vt[i].sr0 = s0; vt[i].nb1 = n1; vt[i].sr1 = s1;
    vt[i].ack = ack; vt[i].err = err; vt[i].nwr = nw;
    vt[i].wa = '0; vt[i].wd = '0;
  endtask

  task automatic set_wr(input int i, input int k, input logic [22:0] a, input logic [15:0] d);
    vt[i].wa[k] = a;
    vt[i].wd[k] = d;
  endtask

  // One clock; outputs sampled 1 ns after the edge, then protocol checks and device model.
  task automatic tick();
    int h;
    @(posedge clk_i);
    #1;
    cyc++;
    if (mon_en) begin
      chk1("we_oe_exclusive", pcm_we_n_o | pcm_oe_n_o, 1'b1);
      if (pcm_dout_t_o != p_dt) chk1("dout_t_switch_idle_strobes", p_we & p_oe, 1'b1);
      if (busy_o) chk1("ce_n_while_busy", pcm_ce_n_o, 1'b0);
      if (ack_o) begin
        chk1("busy_at_ack", busy_o, 1'b0);
        chk1("ack_one_cycle", p_ack, 1'b0);
      end
      if (!pcm_we_n_o) begin
        we_lo++;
        if (p_we) begin
          if (nwr < 16) begin
            wa_log[nwr] = pcm_addr_o;
            wd_log[nwr] = pcm_dout_o;
          end
          nwr++;
          chk1("dout_driven_on_we", pcm_dout_t_o, 1'b0);
          if (pcm_dout_o == 16'h0040) begin
            cmd_cnt++;
            poll_k = 0;
          end
        end
      end else if (!p_we) begin
        chk("we_low_cycles", we_lo, 7);
        we_lo = 0;
      end
      if (!pcm_oe_n_o) begin
        oe_lo++;
        if (p_oe) begin
          chk1("released_on_oe", pcm_dout_t_o, 1'b1);
          poll_k++;
          h = (cmd_cnt - 1) & 1;
          pcm_din_i = (poll_k <= nb[h]) ? 16'hFF7F : {8'h5A, srv[h]};
        end
      end else if (!p_oe) begin
        chk("oe_low_cycles", oe_lo, 7);
        oe_lo = 0;
      end
    end
    if (ack_o) begin
      ack_n++;
      ack_last = cyc;
      if (ack_cyc < 0) ack_cyc = cyc;
    end
    p_we  = pcm_we_n_o;
    p_oe  = pcm_oe_n_o;
    p_dt  = pcm_dout_t_o;
    p_ack = ack_o;
  endtask

  task automatic check_reset(input string nm);
    chk1({nm, "_busy"}, busy_o, 1'b0);
    chk1({nm, "_ack"}, ack_o, 1'b0);
    chk1({nm, "_err"}, err_o, 1'b0);
    chk1({nm, "_ce_n"}, pcm_ce_n_o, 1'b1);
    chk1({nm, "_oe_n"}, pcm_oe_n_o, 1'b1);
    chk1({nm, "_we_n"}, pcm_we_n_o, 1'b1);
    chk1({nm, "_dout_t"}, pcm_dout_t_o, 1'b1);
    chk1({nm, "_rst_n"}, pcm_rst_n_o, 1'b0);
    chk({nm, "_dout"}, 32'(pcm_dout_o), 32'h0);
    chk({nm, "_addr"}, 32'(pcm_addr_o), 32'h0);
  endtask

  task automatic prep(input int i);
    nb[0] = vt[i].nb0; srv[0] = vt[i].sr0;
    nb[1] = vt[i].nb1; srv[1] = vt[i].sr1;
    cmd_cnt = 0; poll_k = 0; nwr = 0; we_lo = 0; oe_lo = 0;
    ack_cyc = -1; ack_n = 0; ack_last = -1;
    addr_i = vt[i].addr; din_i = vt[i].din;
    cyc = 0;
  endtask

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("v%0d", i);
    prep(i);
    cs_i = 1'b1;
    tick();
    chk1({nm, "_busy_after_accept"}, busy_o, 1'b1);
    cs_i = 1'b0;
    while (ack_cyc < 0 && cyc < 2000) tick();
    chk({nm, "_ack_cycle"}, ack_cyc, vt[i].ack);
    chk1({nm, "_err_at_ack"}, err_o, vt[i].err);
    tick();
    chk1({nm, "_err_hold"}, err_o, vt[i].err);
    chk1({nm, "_busy_after_ack"}, busy_o, 1'b0);
    chk({nm, "_num_writes"}, nwr, vt[i].nwr);
    for (int k = 0; k < vt[i].nwr && k < nwr && k < 6; k++) begin
      chk($sformatf("%s_wr%0d_addr", nm, k), 32'(wa_log[k]), 32'(vt[i].wa[k]));
      chk($sformatf("%s_wr%0d_data", nm, k), 32'(wd_log[k]), 32'(vt[i].wd[k]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Expected values: P=7, one phase = 14 cycles, ack at 14P+1 = 99 with no extra polls.
    set_vec(0, 22'h012345, 32'hBEEF_CAFE, 0, 8'h80, 0, 8'h80, 99, 1'b0, 5);
    set_wr(0, 0, 23'h02468A, 16'h0040); set_wr(0, 1, 23'h02468A, 16'hCAFE);
    set_wr(0, 2, 23'h02468B, 16'h0040); set_wr(0, 3, 23'h02468B, 16'hBEEF);
    set_wr(0, 4, 23'h02468A, 16'h00FF);
    set_vec(1, 22'h000001, 32'h1234_5678, 3, 8'h80, 0, 8'h80, 141, 1'b0, 5);
    set_wr(1, 0, 23'h000002, 16'h0040); set_wr(1, 1, 23'h000002, 16'h5678);
    set_wr(1, 2, 23'h000003, 16'h0040); set_wr(1, 3, 23'h000003, 16'h1234);
    set_wr(1, 4, 23'h000002, 16'h00FF);
    set_vec(2, 22'h3FFFFF, 32'hA5A5_0F0F, 0, 8'h90, 0, 8'h80, 71, 1'b1, 4);
    set_wr(2, 0, 23'h7FFFFE, 16'h0040); set_wr(2, 1, 23'h7FFFFE, 16'h0F0F);
    set_wr(2, 2, 23'h7FFFFE, 16'h0050); set_wr(2, 3, 23'h7FFFFE, 16'h00FF);
    set_vec(3, 22'h000000, 32'hFFFF_0000, 0, 8'h80, 2, 8'h82, 141, 1'b1, 6);
    set_wr(3, 0, 23'h000000, 16'h0040); set_wr(3, 1, 23'h000000, 16'h0000);
    set_wr(3, 2, 23'h000001, 16'h0040); set_wr(3, 3, 23'h000001, 16'hFFFF);
    set_wr(3, 4, 23'h000001, 16'h0050); set_wr(3, 5, 23'h000000, 16'h00FF);
    // Status never ready: timeout decided at end of the 8th poll (112 cycles in POLL).
    set_vec(4, 22'h2AAAAA, 32'h0000_1111, 255, 8'h80, 0, 8'h80, 169, 1'b1, 4);
    set_wr(4, 0, 23'h555554, 16'h0040); set_wr(4, 1, 23'h555554, 16'h1111);
    set_wr(4, 2, 23'h555554, 16'h0050); set_wr(4, 3, 23'h555554, 16'h00FF);
    set_vec(5, 22'h000010, 32'h9876_ABCD, 1, 8'h88, 0, 8'h80, 85, 1'b1, 4);
    set_wr(5, 0, 23'h000020, 16'h0040); set_wr(5, 1, 23'h000020, 16'hABCD);
    set_wr(5, 2, 23'h000020, 16'h0050); set_wr(5, 3, 23'h000020, 16'h00FF);

    // Reset state.
    mon_en = 1'b0;
    rst_i = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst_i = 1'b0;
    #1;
    chk1("rst_n_released", pcm_rst_n_o, 1'b1);
    tick();
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // cs held high through the whole operation: exactly one more accept, after DONE.
    prep(0);
    cs_i = 1'b1;
    while (cyc < 330) begin
      tick();
      if (cyc == 99) chk1("hold_busy_at_done", busy_o, 1'b0);
      if (cyc == 100) chk1("hold_busy_idle", busy_o, 1'b0);
      if (cyc == 101) begin
        chk1("hold_busy_reaccept", busy_o, 1'b1);
        cs_i = 1'b0;
      end
    end
    chk("hold_ack_count", ack_n, 2);
    chk("hold_first_ack", ack_cyc, 99);
    chk("hold_second_ack", ack_last, 199);

    // Reset during DATA of half 0: aborts in the same cycle, no ack follows.
    prep(0);
    cs_i = 1'b1;
    tick();
    cs_i = 1'b0;
    while (cyc < 20) tick();
    chk1("pre_rst_we_low", pcm_we_n_o, 1'b0);
    chk("pre_rst_dout", 32'(pcm_dout_o), 32'h0000_CAFE);
    mon_en = 1'b0;
    rst_i = 1'b1;
    #1;
    check_reset("rst_same_cycle");
    tick();
    check_reset("rst_next_cycle");
    rst_i = 1'b0;
    ack_n = 0;
    repeat (150) tick();
    chk("rst_no_ack", ack_n, 0);
    chk1("rst_idle_busy", busy_o, 1'b0);
    mon_en = 1'b1;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
